// File: rtl/rand_roller.sv
// Decelerating pseudo-random roller: a 16-bit Galois LFSR feeds a staged update schedule.
// Define RAND_ROLLER_NOREPEAT_EN to force consecutive final values to differ.
module rand_roller #(
    parameter int WIDTH      = 4,
    parameter int MAX_VAL    = 15,
    parameter int BASE_TICKS = 1_000_000,
    parameter int STEPS      = 5,
    parameter int UPS        = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_value,
    output logic [WIDTH-1:0] o_prev,
    output logic             o_busy,
    output logic             o_done
);
    localparam int CNT_W = $clog2(BASE_TICKS << (STEPS - 1));
    localparam int STG_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int UPD_W = (UPS > 1) ? $clog2(UPS) : 1;
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(STEPS - 1);
    localparam logic [UPD_W-1:0] LAST_UPD   = UPD_W'(UPS - 1);
    localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_VAL);

    typedef enum logic {IDLE, ROLL} state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic [UPD_W-1:0]   upd_q, upd_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [WIDTH-1:0]   final_q, final_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   raw, mapped, final_val;
    logic [31:0]        interval_m1;
    logic               tick_hit, last_upd;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        raw    = lfsr_q[WIDTH-1:0];
        mapped = (raw > MAX_V) ? raw - MAX_V - WIDTH'(1) : raw;
`ifdef RAND_ROLLER_NOREPEAT_EN
        // final_q holds the last final value, i.e. what o_prev will show next
        if (mapped == final_q) begin
            final_val = (mapped == MAX_V) ? '0 : mapped + WIDTH'(1);
        end else begin
            final_val = mapped;
        end
`else
        final_val = mapped;
`endif
        interval_m1 = (32'(BASE_TICKS) << stage_q) - 32'd1;
        tick_hit    = (32'(cnt_q) == interval_m1);
        last_upd    = (stage_q == LAST_STAGE) && (upd_q == LAST_UPD);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        upd_d   = upd_q;
        value_d = value_q;
        prev_d  = prev_q;
        final_d = final_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = ROLL;
                    cnt_d   = '0;
                    stage_d = '0;
                    upd_d   = '0;
                end
            end
            ROLL: begin
                // restart beats stop; a restart leaves the shown value alone
                if (i_start) begin
                    cnt_d   = '0;
                    stage_d = '0;
                    upd_d   = '0;
                end else if (i_stop || (tick_hit && last_upd)) begin
                    value_d = final_val;
                    prev_d  = final_q;
                    final_d = final_val;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tick_hit) begin
                    value_d = mapped;
                    cnt_d   = '0;
                    if (upd_q == LAST_UPD) begin
                        stage_d = stage_q + STG_W'(1);
                        upd_d   = '0;
                    end else begin
                        upd_d = upd_q + UPD_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ROLL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            lfsr_q  <= 16'hACE1;
            cnt_q   <= '0;
            stage_q <= '0;
            upd_q   <= '0;
            value_q <= '0;
            prev_q  <= '0;
            final_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            upd_q   <= upd_d;
            value_q <= value_d;
            prev_q  <= prev_d;
            final_q <= final_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_value = value_q;
    assign o_prev  = prev_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
endmodule

// File: tb/tb_rand_roller.sv
// Bench for rand_roller: table-driven roll scenarios plus randomized short rolls on a MAX_VAL=9 copy.
// Follows RAND_ROLLER_NOREPEAT_EN the same way the design does.
module tb_rand_roller;
    localparam int W     = 4;
    localparam int BT    = 2;
    localparam int STP   = 3;
    localparam int UP    = 2;
    localparam int LAT   = UP * BT * ((1 << STP) - 1);
    localparam int MAXA  = 15;
    localparam int MAXB  = 9;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0, i_stop = 1'b0;
    logic         start9 = 1'b0, stop9 = 1'b0;
    logic [W-1:0] o_value, o_prev, o_value9, o_prev9;
    logic         o_busy, o_done, o_busy9, o_done9;
    logic [15:0]  m_lfsr = 16'h0000;

    int compared = 0;
    int mismatched = 0;
    int exp_value = 0, exp_prev = 0, exp_last = 0;

    typedef struct {
        bit start_stop;
        int stop_off;
        int restart_off;
        int exp_done;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    rand_roller #(.WIDTH(W), .MAX_VAL(MAXA), .BASE_TICKS(BT), .STEPS(STP), .UPS(UP)) u_dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
        .o_value(o_value), .o_prev(o_prev), .o_busy(o_busy), .o_done(o_done)
    );

    rand_roller #(.WIDTH(W), .MAX_VAL(MAXB), .BASE_TICKS(BT), .STEPS(STP), .UPS(UP)) u_dut9 (
        .i_clk(clk), .i_rst(i_rst), .i_start(start9), .i_stop(stop9),
        .o_value(o_value9), .o_prev(o_prev9), .o_busy(o_busy9), .o_done(o_done9)
    );

    // Reference LFSR: holds the value the design will sample at the next rising edge
    always @(posedge clk) begin
        if (i_rst) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int map_val(input logic [15:0] s, input int maxv);
        int raw;
        raw = int'(s) % (1 << W);
        return (raw > maxv) ? raw - (maxv + 1) : raw;
    endfunction

    function automatic int final_of(input logic [15:0] s, input int maxv, input int last);
        int v;
        v = map_val(s, maxv);
`ifdef RAND_ROLLER_NOREPEAT_EN
        if (v == last) v = (v == maxv) ? 0 : v + 1;
`endif
        return v;
    endfunction

    function automatic bit is_update(input int rel);
        for (int s = 0; s < STP; s++)
            for (int k = 0; k < UP; k++)
                if (rel == BT * (UP * ((1 << s) - 1) + (k + 1) * (1 << s))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic rst);
        i_start = start;
        i_stop  = stop;
        i_rst   = rst;
    endtask

    // Returns the LFSR value the design samples at the coming edge, ends at the next falling edge
    task automatic tick(output logic [15:0] s);
        s = m_lfsr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int busy, input int done);
        checkOutput({tag, "_value"}, 32'(o_value), exp_value);
        checkOutput({tag, "_prev"},  32'(o_prev),  exp_prev);
        checkOutput({tag, "_busy"},  32'(o_busy),  busy);
        checkOutput({tag, "_done"},  32'(o_done),  done);
    endtask

    task automatic run_roll(input vec_t v, input string tag);
        logic [15:0] s;
        int base = 0;
        int dut_done_at = -1;
        bit fin = 1'b0;
        applyStimulus(1'b1, v.start_stop, 1'b0);
        tick(s);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check_all({tag, "_t0"}, 1, 0);
        for (int o = 1; o < 200 && !fin; o++) begin
            applyStimulus(o == v.restart_off, o == v.stop_off, 1'b0);
            tick(s);
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (o == v.restart_off) begin
                base = o;
            end else if (o == v.stop_off || (o - base) == LAT) begin
                exp_value = final_of(s, MAXA, exp_last);
                exp_prev  = exp_last;
                exp_last  = exp_value;
                fin = 1'b1;
            end else if (is_update(o - base)) begin
                exp_value = map_val(s, MAXA);
            end
            if (o_done && dut_done_at < 0) dut_done_at = o;
            check_all(tag, fin ? 0 : 1, fin ? 1 : 0);
        end
        checkOutput({tag, "_done_offset"}, 32'(dut_done_at), 32'(v.exp_done));
        for (int i = 0; i < 3; i++) begin
            tick(s);
            check_all({tag, "_after"}, 0, 0);
        end
    endtask

    initial begin
        logic [15:0] s;
        int gap, d, fv, last9, prev_obs, repeats;

        vecs[0] = '{1'b0, 0, 0, LAT};
        vecs[1] = '{1'b0, 5, 0, 5};
        vecs[2] = '{1'b0, 0, 9, 9 + LAT};
        vecs[3] = '{1'b0, 4, 0, 4};
        vecs[4] = '{1'b0, 6, 6, 6 + LAT};
        vecs[5] = '{1'b1, 0, 0, LAT};

        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) tick(s);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check_all("reset", 0, 0);

        for (int i = 0; i < 6; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) tick(s);
            run_roll(vecs[i], $sformatf("vec%0d", i));
        end

        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(s);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check_all("idle_stop", 0, 0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(s);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (9) tick(s);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(s);
        applyStimulus(1'b0, 1'b0, 1'b0);
        exp_value = 0; exp_prev = 0; exp_last = 0;
        check_all("midroll_reset", 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(s);
            check_all("post_reset_idle", 0, 0);
        end
        run_roll(vecs[0], "after_reset");

        last9 = 0; prev_obs = -1; repeats = 0;
        for (int r = 0; r < 1000; r++) begin
            d = $urandom_range(1, 3);
            start9 = 1'b1;
            tick(s);
            start9 = 1'b0;
            for (int o = 1; o <= d; o++) begin
                stop9 = (o == d);
                tick(s);
                stop9 = 1'b0;
            end
            fv = final_of(s, MAXB, last9);
            checkOutput("roll9_final", 32'(o_value9), fv);
            checkOutput("roll9_range", 32'(o_value9 <= 4'(MAXB)), 1);
            checkOutput("roll9_prev", 32'(o_prev9), last9);
            checkOutput("roll9_done", 32'(o_done9), 1);
            if (int'(o_value9) == prev_obs) repeats++;
            prev_obs = int'(o_value9);
            last9 = fv;
        end
`ifdef RAND_ROLLER_NOREPEAT_EN
        checkOutput("roll9_repeats", 32'(repeats), 0);
`else
        checkOutput("roll9_repeat_seen", 32'(repeats > 0), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rand_roller.md
# rand_roller

- Parametrised random-number roller for the DE2-115 lab designs.
- On a start pulse it shows a stream of pseudo-random values whose update rate slows down stage by stage, then settles on a final value.
- Sits between the debounced key pulse and the seven-segment decoder, replacing the fixed 4-bit, fixed-timing generator.
- Adds generic range, an early-stop request and previous-result capture.

## Interface
- WIDTH, 4: output value width, 1..16
- MAX_VAL, 15: largest output value; legal range 2^(WIDTH-1)-1 ≤ MAX_VAL ≤ 2^WIDTH-1
- BASE_TICKS, 1_000_000: clock cycles between updates in stage 0, ≥ 2
- STEPS, 5: number of deceleration stages, ≥ 1
- UPS, 4: updates per stage, ≥ 1
- i_clk  in  1  system clock, 50 MHz
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle start pulse, from the debouncer
- i_stop  in  1  one-cycle early-stop pulse
- o_value  out  WIDTH  current displayed value
- o_prev  out  WIDTH  final value of the previous completed roll
- o_busy  out  1  high while rolling
- o_done  out  1  one-cycle pulse when the final value is latched

## Operation

**LFSR**
- 16-bit Galois LFSR, shift right, tap mask 16'hB400.
- Runs every cycle from reset; the reset value is 16'hACE1.
- Never all-zero.

**Mapping**
- raw = lfsr[WIDTH-1:0].
- mapped = raw > MAX_VAL ? raw-(MAX_VAL+1) : raw.
- One conditional subtraction only; the bias is accepted.

**FSM states: IDLE, ROLL**
- IDLE + i_start:
  - go to ROLL.
  - stage = 0, upd = 0, cnt = 0, interval = BASE_TICKS.
- ROLL, normal counting:
  - cnt increments each cycle.
  - When cnt == interval-1: o_value <= mapped, cnt <= 0, upd increments.
  - When upd reaches UPS: stage increments, upd <= 0, interval = BASE_TICKS << stage.
- ROLL, final update (update number STEPS*UPS):
  - o_value <= final value.
  - o_prev <= old final value.
  - o_done pulses; go to IDLE.
- ROLL + i_stop: the final update happens at that same edge, then go to IDLE.
- ROLL + i_start: restart from stage 0; o_value keeps its current value.
- Simultaneous i_start and i_stop:
  - In ROLL, start wins (restart).
  - In IDLE, start is taken and stop is ignored.
- i_stop in IDLE is ignored.
- The counter is ceil(log2(BASE_TICKS << (STEPS-1))) bits wide.

## Timing
- Reset values:
  - o_value = 0, o_prev = 0, o_busy = 0, o_done = 0.
  - FSM in IDLE, lfsr = 16'hACE1.
- Reset mid-roll aborts the roll immediately. No o_done pulse is produced and o_prev is unchanged from its reset value.
- i_start is sampled at edge t0; o_busy goes high from t0.
- Update edges:
  - Update k of stage s happens at t0 + BASE_TICKS·(UPS·(2^s − 1) + (k+1)·2^s), with k = 0..UPS-1.
  - Total roll latency is UPS·BASE_TICKS·(2^STEPS − 1) cycles.
  - With the defaults this is 124,000,000 cycles, about 2.48 s.
- o_done is registered and high for exactly the one cycle after the final-update edge. o_busy is low in that same cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- RAND_ROLLER_NOREPEAT_EN defined:
  - At the final update, if mapped == o_value_final_prev (the current o_prev-candidate), the final value is mapped+1.
  - If mapped == MAX_VAL, the final value wraps to 0.
  - Consecutive final results therefore always differ.
  - Intermediate updates are unaffected.
- Undefined:
  - The final value is plain mapped; repeats are allowed.

## Test plan
Bench parameters for all scenarios: WIDTH=4, MAX_VAL=15, BASE_TICKS=2, STEPS=3, UPS=2. The bench runs a bit-exact LFSR model.

- **Reset defaults:** assert i_rst 3 cycles, release. Required: all outputs 0, o_busy=0.
- **Normal roll:** start at t0.
  - o_value updates at t0+2, +4, +8, +12, +20, +28, each update equal to the model's mapped value.
  - o_done is high for one cycle after t0+28 and o_busy falls at the same time.
- **Early stop:** start at t0, stop at t0+5.
  - Updates at t0+2 and t0+4, final update at t0+5.
  - o_done is high after t0+5 and no further updates occur.
- **Restart:** start at t0, start again at t0+9.
  - Done arrives at t0+9+28.
  - o_prev is unchanged until that point, then equals the prior final value.
- **Mapping and no-repeat:**
  - Rerun with MAX_VAL=9 and check mapped values across 1000 rolls are all ≤ 9.
  - With RAND_ROLLER_NOREPEAT_EN defined, no two consecutive finals are equal. Without the macro, at least one repeat occurs in 1000 rolls with MAX_VAL=9.
- **Reset mid-roll:** assert i_rst at t0+10. Required: o_busy=0, o_value=0, no o_done pulse; a following start behaves exactly as in the normal-roll scenario.
